mac_dot_product: RTL and testbench
==================================

Name: mac_dot_product

Overview:
- Sequential dot-product engine that sits directly downstream of the team's 8x8 unsigned combinational array multiplier.
- It instantiates one multiplier and streams operand pairs into it under a valid/ready handshake.
- It registers each 16-bit product and accumulates a programmable number of products.
- It returns the sum through an output valid/ready handshake.
- Typical consumer: FIR/correlation datapath in the same design.

Parameters:
- ACC_W, 24, accumulator and result width in bits; legal range 16..32.
- LEN_W, 8, width of the transaction length field; maximum terms per transaction is 2^LEN_W-1.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising clk edge.
- start  input  1  begin a transaction; honoured only in IDLE.
- len  input  LEN_W  number of operand pairs to accumulate; sampled with start.
- in_valid  input  1  operand pair on a/b is valid.
- in_ready  output  1  engine accepts a pair this cycle.
- a  input  8  unsigned multiplicand.
- b  input  8  unsigned multiplier.
- out_valid  output  1  result is valid and held stable.
- out_ready  input  1  consumer accepts the result.
- result  output  ACC_W  unsigned sum of products.
- overflow  output  1  sticky carry out of the accumulator for the current transaction.
- busy  output  1  high in any state other than IDLE.

Behaviour:
Reset:
- While rst_n is low at a clk edge, the FSM goes to IDLE.
- Accumulator, count, product register, pipeline valid, result and overflow are all cleared to 0.
- in_ready, out_valid and busy are 0.
- Reset mid-transaction abandons it: no result is produced, and partial state is discarded.

FSM (IDLE, RUN, DRAIN, DONE):
- IDLE: in_ready=0. On start=1:
  - latch len into the remaining counter; clear acc and overflow.
  - go to RUN if len!=0; go to DONE with result=0 if len==0.
- RUN: in_ready=1.
  - A pair is accepted when in_valid && in_ready.
  - On accept, register a/b into the operand regs, set the pipe-valid bit, and decrement remaining.
  - When the last pair is accepted (remaining==1), go to DRAIN. in_ready drops the cycle after that accept.
- DRAIN: in_ready=0. The pending product is added. Go to DONE the next cycle.
- DONE: out_valid=1; result and overflow are held stable.
  - When out_ready=1, go to IDLE; out_valid drops the next cycle.
- start is ignored in RUN, DRAIN and DONE.

Datapath and pipeline:
- Stage 1: operand regs feed the combinational multiplier; the 16-bit product is the multiplier output.
- Stage 2: acc <= acc + zero-extended product, when pipe-valid is set.
- A pair accepted at edge k is reflected in acc at edge k+2.
- result equals acc on entry to DONE.
- From the last accept to out_valid is exactly 2 cycles.
- Gaps in in_valid in RUN are legal; no accept means no decrement and no add beyond the already-pending product.

Arithmetic:
- Unsigned throughout. acc wraps modulo 2^ACC_W.
- overflow is set when the add produces a carry out of bit ACC_W-1, stays set until the next start, and is valid with result.
- At defaults (255 x 65025 = 16,581,375 < 2^24) overflow cannot occur; it can with smaller ACC_W.

Boundary conditions:
- A simultaneous accept and last count moves to DRAIN that edge.
- Back-to-back transactions: start is sampled earliest in the cycle after the DONE handshake, giving a minimum 1 IDLE cycle.
- An out_ready pulse before DONE has no effect.

Test Plan:
1. Reset then start, len=3, pairs (2,3),(4,5),(255,255) with in_valid held high -> out_valid is high 2 cycles after the 3rd accept; result=65051; overflow=0; busy is high from the cycle after start until the DONE handshake.
2. start with len=0 -> DONE the next cycle; result=0; overflow=0; no in_ready pulse.
3. len=255, all pairs (255,255), in_valid toggling 1/0 -> exactly 255 accepts; result=16,581,375; overflow=0.
4. ACC_W=16, len=2, pairs (255,255),(255,255) -> result=130050 mod 65536=64514; overflow=1. Then a next transaction with len=1, pair (1,1) -> result=1, overflow=0.
5. out_ready held low for 5 cycles in DONE -> result and out_valid stay stable; a start pulse during this time is ignored. Raising out_ready returns the engine to IDLE the following cycle.
6. rst_n low for 1 cycle after 2 of 4 pairs are accepted -> all outputs are 0 the next cycle. A new start with len=1, pair (7,9) -> result=63.

Source files
------------

// File: rtl/mac_dot_product_if.sv
// Handshake/bus interface for mac_dot_product.
// Carries the transaction start/length, the operand stream with its
// valid/ready handshake, the result stream with its valid/ready handshake,
// and the status flags.
//   master : the side that issues transactions and consumes results
//   slave  : the dot-product engine
interface mac_dot_product_if #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       a;
  logic [7:0]       b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] result;
  logic             overflow;
  logic             busy;

  modport master (
    output start, len, in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, overflow, busy
  );

  modport slave (
    input  start, len, in_valid, a, b, out_ready,
    output in_ready, out_valid, result, overflow, busy
  );
endinterface

// File: rtl/mac_dot_product.sv
// Sequential unsigned dot-product engine.
// Streams 8-bit operand pairs through an 8x8 combinational array multiplier,
// registers each 16-bit product and accumulates LEN products into an
// ACC_W-bit wrapping accumulator with a sticky carry-out flag.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : mac_dot_product_if.slave (start/len, a/b in_valid/in_ready,
//           result/overflow out_valid/out_ready, busy)

// 8x8 unsigned combinational array multiplier (shift-and-add of partial products).
module array_mult_8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] prod
);
  always_comb begin
    prod = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) prod = prod + ({8'd0, a} << i);
    end
  end
endmodule

module mac_dot_product #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  mac_dot_product_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [LEN_W-1:0] remaining;
  logic             accept;

  logic [7:0]       a_p0;
  logic [7:0]       b_p0;
  logic             vld_p0;
  logic [15:0]      prod_c;
  logic [15:0]      prod_p1;
  logic             vld_p1;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [ACC_W:0]   sum;

  // Accumulate with the carry out of the top bit returned as the MSB.
  function automatic logic [ACC_W:0] add_carry(input logic [ACC_W-1:0] x,
                                                input logic [15:0]      p);
    return {1'b0, x} + {{(ACC_W-15){1'b0}}, p};
  endfunction

  assign accept = (state == S_RUN) && bus.in_valid;
  assign sum    = add_carry(acc, prod_p1);

  array_mult_8x8 u_mult (
    .a    (a_p0),
    .b    (b_p0),
    .prod (prod_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      remaining <= '0;
      a_p0      <= '0;
      b_p0      <= '0;
      vld_p0    <= 1'b0;
      prod_p1   <= '0;
      vld_p1    <= 1'b0;
      acc       <= '0;
      ovf       <= 1'b0;
    end else begin
      // p0: operand capture on accept
      vld_p0 <= accept;
      if (accept) begin
        a_p0 <= bus.a;
        b_p0 <= bus.b;
      end
      // p1: product register
      vld_p1 <= vld_p0;
      if (vld_p0) prod_p1 <= prod_c;
      // p2: accumulate, carry is sticky for the transaction
      if (vld_p1) begin
        acc <= sum[ACC_W-1:0];
        ovf <= ovf | sum[ACC_W];
      end

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            remaining <= bus.len;
            acc       <= '0;
            ovf       <= 1'b0;
            state     <= (bus.len == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Once the operand stage is empty, the final product is being
          // added on this edge, so acc is complete on entry to DONE.
          if (!vld_p0) state <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_RUN);
  assign bus.out_valid = (state == S_DONE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.result    = acc;
  assign bus.overflow  = ovf;
endmodule

// File: tb/tb_mac_dot_product.sv
module tb_mac_dot_product;
  typedef struct packed {
    logic        ovf;
    logic [31:0] res;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_dot_product_if #(.ACC_W(24), .LEN_W(8)) bus ();
  mac_dot_product_if #(.ACC_W(16), .LEN_W(8)) bus16 ();

  mac_dot_product #(.ACC_W(24), .LEN_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mac_dot_product #(.ACC_W(16), .LEN_W(8)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  exp_t exp16_q[$];
  logic [7:0] pa [256];
  logic [7:0] pb [256];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: running unsigned sum with wrap at 2^w and sticky carry.
  function automatic exp_t model(input int n, input int w);
    longint acc = 0;
    longint lim = longint'(1) << w;
    exp_t   e;
    e.ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      acc = acc + longint'(pa[i]) * longint'(pb[i]);
      if (acc >= lim) begin
        acc   = acc - lim;
        e.ovf = 1'b1;
      end
    end
    e.res = 32'(acc);
    return e;
  endfunction

  task automatic start_txn(input int n);
    bus.start = 1'b1;
    bus.len   = 8'(n);
    step();
    bus.start = 1'b0;
  endtask

  task automatic feed(input int n, input bit toggle);
    int  idx = 0;
    int  guard = 0;
    bit  ph = 1'b0;
    bit  acc_now;
    while (idx < n && guard < 2000) begin
      bus.in_valid = toggle ? !ph : 1'b1;
      ph = !ph;
      bus.a = pa[idx];
      bus.b = pb[idx];
      acc_now = bus.in_valid && bus.in_ready;
      step();
      guard++;
      if (acc_now) idx++;
    end
    bus.in_valid = 1'b0;
    if (idx < n) chk("feed_timeout", 64'(idx), 64'(n));
  endtask

  // Called right after the last-accept edge.
  task automatic lat_check(input string tag);
    chk({tag, "_drain_in_ready"}, 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    step();
    chk({tag, "_k1_out_valid"}, 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b0;
    step();
    chk({tag, "_k2_out_valid"}, 64'(bus.out_valid), 64'd1);
  endtask

  task automatic collect(input string tag);
    int   g = 0;
    exp_t e;
    while (!bus.out_valid && g < 50) begin
      step();
      g++;
    end
    chk({tag, "_out_valid_seen"}, 64'(bus.out_valid), 64'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 64'd0, 64'd1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    chk({tag, "_result"}, 64'(bus.result), 64'(e.res));
    chk({tag, "_overflow"}, 64'(bus.overflow), 64'(e.ovf));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_post_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_post_busy"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic run16(input string tag, input int n, input logic [7:0] av, input logic [7:0] bv);
    int   got = 0;
    int   g = 0;
    bit   acc_now;
    exp_t e;
    bus16.start = 1'b1;
    bus16.len   = 8'(n);
    step();
    bus16.start = 1'b0;
    bus16.a = av;
    bus16.b = bv;
    while (got < n && g < 100) begin
      bus16.in_valid = 1'b1;
      acc_now = bus16.in_ready;
      step();
      g++;
      if (acc_now) got++;
    end
    bus16.in_valid = 1'b0;
    g = 0;
    while (!bus16.out_valid && g < 50) begin
      step();
      g++;
    end
    chk({tag, "_out_valid_seen"}, 64'(bus16.out_valid), 64'd1);
    e = (exp16_q.size() != 0) ? exp16_q.pop_front() : '0;
    chk({tag, "_result"}, 64'(bus16.result), 64'(e.res));
    chk({tag, "_overflow"}, 64'(bus16.overflow), 64'(e.ovf));
    bus16.out_ready = 1'b1;
    step();
    bus16.out_ready = 1'b0;
    chk({tag, "_post_out_valid"}, 64'(bus16.out_valid), 64'd0);
  endtask

  initial begin
    exp_t e;
    bus.start = 0; bus.len = 0; bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.out_ready = 0;
    bus16.start = 0; bus16.len = 0; bus16.in_valid = 0; bus16.a = 0; bus16.b = 0; bus16.out_ready = 0;

    // Reset state
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_overflow", 64'(bus.overflow), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);

    // 1: len=3, in_valid held high
    pa[0] = 2; pb[0] = 3; pa[1] = 4; pb[1] = 5; pa[2] = 255; pb[2] = 255;
    e = model(3, 24);
    chk("t1_model", 64'(e.res), 64'd65051);
    exp_q.push_back(e);
    start_txn(3);
    chk("t1_busy_after_start", 64'(bus.busy), 64'd1);
    feed(3, 1'b0);
    lat_check("t1");
    chk("t1_busy_done", 64'(bus.busy), 64'd1);
    collect("t1");

    // 2: len=0 goes straight to DONE
    step();
    exp_q.push_back('0);
    start_txn(0);
    chk("t2_out_valid", 64'(bus.out_valid), 64'd1);
    chk("t2_in_ready", 64'(bus.in_ready), 64'd0);
    collect("t2");

    // 3: len=255, all (255,255), in_valid toggling
    step();
    for (int i = 0; i < 255; i++) begin
      pa[i] = 8'd255;
      pb[i] = 8'd255;
    end
    e = model(255, 24);
    chk("t3_model", 64'(e.res), 64'd16581375);
    exp_q.push_back(e);
    start_txn(255);
    feed(255, 1'b1);
    lat_check("t3");
    collect("t3");

    // 4: ACC_W=16 overflow, then overflow cleared by the next start
    pa[0] = 255; pb[0] = 255; pa[1] = 255; pb[1] = 255;
    e = model(2, 16);
    chk("t4_model", 64'(e.res), 64'd64514);
    exp16_q.push_back(e);
    run16("t4a", 2, 8'd255, 8'd255);
    step();
    pa[0] = 1; pb[0] = 1;
    exp16_q.push_back(model(1, 16));
    run16("t4b", 1, 8'd1, 8'd1);

    // 5: result held while out_ready stays low; start ignored in DONE
    step();
    pa[0] = 3; pb[0] = 4;
    exp_q.push_back(model(1, 24));
    start_txn(1);
    feed(1, 1'b0);
    for (int g = 0; g < 50 && !bus.out_valid; g++) step();
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_out_valid", 64'(bus.out_valid), 64'd1);
      chk("t5_hold_result", 64'(bus.result), 64'd12);
      if (i == 2) begin
        bus.start = 1'b1;
        bus.len   = 8'd5;
      end
      step();
      bus.start = 1'b0;
    end
    chk("t5_still_done", 64'(bus.out_valid), 64'd1);
    collect("t5");
    step();
    chk("t5_idle_after", 64'(bus.busy), 64'd0);

    // 6: reset after 2 of 4 accepts abandons the transaction
    for (int i = 0; i < 4; i++) begin
      pa[i] = 8'(i + 10);
      pb[i] = 8'(i + 20);
    end
    start_txn(4);
    feed(2, 1'b0);
    chk("t6_mid_busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_rst_result", 64'(bus.result), 64'd0);
    chk("t6_rst_overflow", 64'(bus.overflow), 64'd0);
    chk("t6_rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("t6_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_rst_busy", 64'(bus.busy), 64'd0);
    pa[0] = 7; pb[0] = 9;
    e = model(1, 24);
    chk("t6_model", 64'(e.res), 64'd63);
    exp_q.push_back(e);
    start_txn(1);
    feed(1, 1'b0);
    collect("t6");
    chk("t6_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
